// File: rtl/irrigation_scheduler_if.sv
// rtl/irrigation_scheduler_if.sv - sensor/enable inputs and valve/pump/status outputs of the irrigation scheduler
interface irrigation_scheduler_if;
    logic       enable;
    logic [1:0] dry;
    logic [1:0] valve;
    logic       pump;
    logic       busy;
    logic [1:0] fault;
    logic [7:0] seg;

    modport master (output enable, dry, input valve, pump, busy, fault, seg);
    modport slave  (input enable, dry, output valve, pump, busy, fault, seg);
endinterface

// File: rtl/irrigation_scheduler.sv
// rtl/irrigation_scheduler.sv - round-robin pump/valve sequencer for two garden areas
// Optional IRRIG_FAULT_MASK_EN: a timed-out area is excluded from arbitration until reset.
module irrigation_scheduler #(
    parameter int SETTLE    = 2,
    parameter int WATER_MIN = 8,
    parameter int WATER_MAX = 32,
    parameter int CNT_W     = 6
) (
    input  logic                  clk_2,
    input  logic                  reset,
    irrigation_scheduler_if.slave io
);
    typedef enum logic [1:0] {IDLE, PRIME, WATER, DRAIN} state_t;

    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] MIN_END    = CNT_W'(WATER_MIN - 1);
    localparam logic [CNT_W-1:0] MAX_END    = CNT_W'(WATER_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             g_q, g_d;
    logic             last_q, last_d;
    logic [1:0]       fault_q, fault_d;
    logic [1:0]       valve_q, valve_d;
    logic             pump_q, pump_d;
    logic             busy_q, busy_d;
    logic [7:0]       seg_q, seg_d;
    logic [1:0]       eligible;
    logic             timeout, done;
    logic [6:0]       digit;

    always_comb begin
`ifdef IRRIG_FAULT_MASK_EN
        eligible = {2{io.enable}} & io.dry & ~fault_q;
`else
        eligible = {2{io.enable}} & io.dry;
`endif
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        fault_d = fault_q;
        timeout = (cnt_q == MAX_END);
        done    = (cnt_q >= MIN_END) && !io.dry[g_q];

        case (state_q)
            IDLE: begin
                if (eligible != 2'b00) begin
                    // On a tie the area not served last time wins.
                    g_d     = (eligible == 2'b11) ? ~last_q : eligible[1];
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (cnt_q == SETTLE_END) state_d = WATER;
            end
            WATER: begin
                if (!io.enable || done || timeout) state_d = DRAIN;
                if (timeout && io.dry[g_q]) fault_d[g_q] = 1'b1;
            end
            DRAIN: begin
                if (cnt_q == SETTLE_END) begin
                    state_d = IDLE;
                    last_d  = g_q;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

        // Outputs are decoded from the next state so they register alongside it.
        digit   = g_d ? 7'h06 : 7'h3F;
        valve_d = (state_d == IDLE) ? 2'b00 : (g_d ? 2'b10 : 2'b01);
        pump_d  = (state_d == WATER);
        busy_d  = (state_d != IDLE);
        seg_d   = (state_d == IDLE) ? 8'h00 : {state_d != WATER, digit};
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            g_q     <= 1'b0;
            last_q  <= 1'b1;
            fault_q <= 2'b00;
            valve_q <= 2'b00;
            pump_q  <= 1'b0;
            busy_q  <= 1'b0;
            seg_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            last_q  <= last_d;
            fault_q <= fault_d;
            valve_q <= valve_d;
            pump_q  <= pump_d;
            busy_q  <= busy_d;
            seg_q   <= seg_d;
        end
    end

    assign io.valve = valve_q;
    assign io.pump  = pump_q;
    assign io.busy  = busy_q;
    assign io.fault = fault_q;
    assign io.seg   = seg_q;
endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
- Sequences one shared irrigation pump between two garden areas that each report low humidity.
- Takes the two dryness sensors (SWI-level signals), arbitrates round-robin, and opens each area's valve before starting the pump.
- Enforces a minimum and a maximum watering time and flags stuck sensors.
- Drives the board's LED and 7-segment outputs, and sits beside the existing humidity display logic in the top-level.

Parameters:
- SETTLE, 2: cycles the valve stays open with the pump off, both before and after watering.
- WATER_MIN, 8: minimum pump-on cycles per grant.
- WATER_MAX, 32: maximum pump-on cycles per grant; timeout limit.
- CNT_W, 6: width of the state cycle counter; must satisfy 2^CNT_W > max(WATER_MAX, SETTLE).

Ports:
- clk_2 input 1: system clock, rising edge.
- reset input 1: asynchronous, active-high reset.
- enable input 1: global watering enable.
- dry input 2: dry[i]=1 means area i humidity is low.
- valve output 2: valve[i]=1 means area i valve is open; one-hot or zero.
- pump output 1: pump on.
- busy output 1: high in any state other than IDLE.
- fault output 2: sticky timeout flag per area.
- seg output 8: 7-segment code, gfedcba in bits 6:0, decimal point in bit 7.

Behaviour:
- States: IDLE, PRIME, WATER, DRAIN.
- Registers: 1-bit grant g, 1-bit last-served pointer, CNT_W counter. The counter clears on every state entry and increments each cycle within a state.
- All outputs are decoded from registered state (Moore).
- Reset (async, takes effect immediately):
  - state=IDLE, cnt=0, g=0, last=1 (area 0 wins the first tie), fault=00.
  - Outputs: valve=00, pump=0, busy=0, seg=0x00.
- IDLE:
  - valve=00, pump=0.
  - eligible[i] = enable & dry[i] (see Optional Feature for fault masking).
  - If any area is eligible: exactly one eligible area → g = that area; both eligible → g = ~last. Then go to PRIME.
  - Timing: dry sampled high at edge N leads to valve[g]=1 after edge N.
- PRIME: valve[g]=1, pump=0. After SETTLE cycles go to WATER. Valve is always open before the pump starts.
- WATER: valve[g]=1, pump=1. Leave for DRAIN at the first cycle where any of these holds:
  - (a) cnt >= WATER_MIN-1 and dry[g]=0 (normal completion);
  - (b) cnt == WATER_MAX-1: if dry[g] is still 1, set fault[g]<=1 on the same edge;
  - (c) enable=0: immediate abort, WATER_MIN not enforced.
- DRAIN: pump=0, valve[g]=1 for SETTLE cycles, then go to IDLE and set last<=g. The valve never closes while the pump is on.
- dry[~g] changes during a grant are ignored until the grant returns to IDLE; there is no preemption.
- seg encoding:
  - IDLE: 0x00.
  - WATER: g=0 → 0x3F ('0'); g=1 → 0x06 ('1').
  - PRIME/DRAIN: same digit with bit 7 set (0xBF / 0x86).
- fault bits clear only on reset. enable=0 in PRIME still completes PRIME→WATER→abort→DRAIN; no state skips DRAIN.
- Invariants: pump=1 implies valve is one-hot; valve=11 never occurs.

Optional Feature:
- Macro: IRRIG_FAULT_MASK_EN.
- Defined: eligible[i] = enable & dry[i] & ~fault[i]. A faulted area is never granted again until reset.
- Undefined: fault is report-only; a faulted area keeps competing normally and may re-time out. fault stays set.

Test Plan:
- Single request: reset, enable=1, dry=01 for 1 cycle, then 00.
  - valve=01 for 2+8+2=12 cycles.
  - pump=1 exactly 8 cycles, starting 2 cycles after valve.
  - seg sequence 0xBF → 0x3F → 0xBF → 0x00; busy drops with valve.
- Round-robin: dry=11 held until each area has had one grant.
  - Area 0 is served first, then area 1 immediately after area 0's DRAIN; pump never overlaps two valves.
- Timeout: dry=10 held high.
  - pump high 32 cycles, fault=10 set at the end.
  - With IRRIG_FAULT_MASK_EN: remains IDLE with dry=10; dry=11 then grants area 0 only.
  - Without the macro: area 1 is re-granted.
- Abort: enable falls at WATER cnt=3.
  - pump=0 after the next edge; valve held 2 more cycles, then 00; fault unchanged.
- Async reset mid-WATER: assert reset between edges.
  - valve=00, pump=0, seg=0x00, fault=00 immediately, without waiting for a clock edge.
  - After release with dry=11, area 0 is granted first.
- Disabled: enable=0, dry=11 for 50 cycles → busy=0, valve=00, pump=0 throughout.
